pixel_stream_loader: RTL and testbench
======================================

Name: pixel_stream_loader

Overview:
- Upstream feeder for convolution_top.
- Accepts a valid/ready byte stream of raster-order pixels and converts it into the addressed write interface (pixel_in / pixel_addr / pixel_we) that fills the convolution input buffer.
- After a full frame it pulses start, then blocks the stream until the convolution engine reports done.
- Performs frame-length checking and counts completed frames.

Parameters:
- IMAGE_WIDTH, 256, pixels per line.
- IMAGE_HEIGHT, 256, lines per frame.
- ADDR_W, $clog2(IMAGE_WIDTH*IMAGE_HEIGHT), pixel address width.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  asynchronous active-high reset.
- s_data  input  8  stream pixel value.
- s_valid  input  1  stream beat valid.
- s_last  input  1  marks final pixel of a frame.
- s_ready  output  1  loader can accept a beat.
- pixel_in  output  8  pixel to convolution_top.
- pixel_addr  output  ADDR_W  write address to convolution_top.
- pixel_we  output  1  write enable to convolution_top.
- start  output  1  one-cycle start pulse to convolution_top.
- conv_done  input  1  done from convolution_top (level; may stay high).
- busy  output  1  frame in progress (partial load, start, or waiting).
- frame_err  output  1  one-cycle pulse on frame length mismatch.
- frame_count  output  16  completed frames, wraps at 0xFFFF->0.

Behaviour:
- Interface and reset:
  - Reset values: s_ready=0, pixel_in=0, pixel_addr=0, pixel_we=0, start=0, busy=0, frame_err=0, frame_count=0, beat counter=0, state=LOAD.
  - s_ready goes high the first cycle after rst deasserts.
  - Reset asserted mid-operation discards any partial frame; the next accepted beat is written to address 0.
- N = IMAGE_WIDTH*IMAGE_HEIGHT. Beat accepted = s_valid & s_ready.
- States: LOAD, GAP, START, WAIT_DONE.
- LOAD:
  - s_ready=1.
  - On an accepted beat at counter value k, the next cycle drives pixel_we=1, pixel_addr=k, pixel_in=s_data. Latency is exactly 1 cycle.
  - Cycles with no accepted beat drive pixel_we=0, while pixel_addr and pixel_in hold their values. Counter increments per accepted beat.
  - s_last on beat k<N-1 (short frame):
    - frame_err pulses next cycle and the beat is still written.
    - Counter returns to 0, state stays LOAD, no start is issued.
  - Beat k=N-1:
    - Counter returns to 0 and state goes to GAP.
    - If s_last=0 on this beat, frame_err pulses next cycle and the frame is still processed. The following beats belong to the next frame.
- GAP:
  - One cycle, s_ready=0. The final pixel_we occurs in this cycle.
  - Go to START.
- START:
  - One cycle, start=1, pixel_we=0, s_ready=0.
  - Go to WAIT_DONE.
  - start is never asserted in the same cycle as pixel_we.
- WAIT_DONE:
  - s_ready=0.
  - conv_done is registered every cycle (conv_done_d). A rising edge (conv_done & ~conv_done_d) is required; a stale high level from an earlier frame is ignored.
  - On the rising edge: frame_count increments next cycle and state goes to LOAD, so s_ready=1 the following cycle.
- busy = (state!=LOAD) | (counter!=0).
- s_data and s_last are ignored while s_ready=0.
- frame_err pulses are never merged; each error gives one 1-cycle pulse.

Test Plan (IMAGE_WIDTH=4, IMAGE_HEIGHT=4, N=16):
- Continuous frame of bytes 0x00..0x0F, s_last on the 16th beat -> pixel_we high 16 consecutive cycles with addr 0..15 and matching data. s_ready=0 the cycle after the last accept. start=1 exactly once, 2 cycles after the last accept. frame_err never pulses.
- Same frame with s_valid low on every other cycle -> pixel_we only in the cycle after each accepted beat. Addresses 0..15 contiguous with no repeats. Single start pulse.
- After the start pulse, hold conv_done=0 for 50 cycles -> s_ready stays 0. conv_done rises -> frame_count=1 and s_ready=1 one cycle later. Keep conv_done high through a second full frame -> no exit from WAIT_DONE until conv_done falls and rises again, then frame_count=2.
- s_last on beat 5 (addr 4) -> frame_err pulse, no start. The next 16 beats are written to addresses 0..15 and followed by exactly one start.
- 16 beats with s_last=0 throughout -> frame_err pulses once, the cycle after the 16th accept. start is still issued.
- Assert rst after 7 accepted beats -> all outputs return to reset values immediately. After release, the first beat is written to address 0 and a full frame yields exactly one start.

Source files
------------

// File: rtl/pixel_stream_loader.sv
`default_nettype none
// ============================================================================
//  Module      : pixel_stream_loader
//  Description : Converts a valid/ready raster-order byte stream into the
//                addressed pixel write port of convolution_top. After a full
//                frame it pulses start and holds the stream off until the
//                engine reports a fresh done edge. Checks frame length and
//                counts completed frames.
//  Revision    : 1.0 - initial release
// ============================================================================
module pixel_stream_loader #(
  parameter int IMAGE_WIDTH  = 256,
  parameter int IMAGE_HEIGHT = 256,
  parameter int ADDR_W       = $clog2(IMAGE_WIDTH * IMAGE_HEIGHT)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [7:0]        s_data,
  input  logic              s_valid,
  input  logic              s_last,
  output logic              s_ready,
  output logic [7:0]        pixel_in,
  output logic [ADDR_W-1:0] pixel_addr,
  output logic              pixel_we,
  output logic              start,
  input  logic              conv_done,
  output logic              busy,
  output logic              frame_err,
  output logic [15:0]       frame_count
);

  localparam int              NPIX     = IMAGE_WIDTH * IMAGE_HEIGHT;
  localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(NPIX - 1);

  typedef enum logic [1:0] {
    LOAD      = 2'd0,
    GAP       = 2'd1,
    START     = 2'd2,
    WAIT_DONE = 2'd3
  } state_t;

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] cnt_q, cnt_d;
  logic [15:0]       frame_count_q, frame_count_d;
  logic              conv_done_q;
  logic              s_ready_q, s_ready_d;
  logic              start_q, start_d;
  logic              pixel_we_q, pixel_we_d;
  logic [ADDR_W-1:0] pixel_addr_q, pixel_addr_d;
  logic [7:0]        pixel_in_q, pixel_in_d;
  logic              frame_err_q, frame_err_d;

  logic accept;
  logic at_last_idx;
  logic done_rise;

  // s_ready is registered, so it is only ever high while state_q is LOAD.
  assign accept      = s_valid & s_ready_q;
  assign at_last_idx = (cnt_q == LAST_IDX);
  // Only a fresh rising edge counts; a level left high from an earlier
  // frame must not release the next one.
  assign done_rise   = conv_done & ~conv_done_q;

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= LOAD;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state, beat counter, frame counter and registered output values
  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    frame_count_d = frame_count_q;

    case (state_q)
      LOAD: begin
        if (accept) begin
          if (at_last_idx) begin
            // Full frame reached: a missing s_last is flagged below but the
            // frame is still handed to the engine.
            cnt_d   = '0;
            state_d = GAP;
          end else if (s_last) begin
            // Short frame: restart addressing, no start.
            cnt_d = '0;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end
      GAP: begin
        state_d = START;
      end
      START: begin
        state_d = WAIT_DONE;
      end
      WAIT_DONE: begin
        if (done_rise) begin
          state_d       = LOAD;
          frame_count_d = frame_count_q + 16'd1;
        end
      end
      default: begin
        state_d = LOAD;
      end
    endcase

    s_ready_d    = (state_d == LOAD);
    start_d      = (state_d == START);
    pixel_we_d   = accept;
    pixel_addr_d = accept ? cnt_q  : pixel_addr_q;
    pixel_in_d   = accept ? s_data : pixel_in_q;
    // Length error: s_last early, or missing on the final beat.
    frame_err_d  = accept & (s_last ^ at_last_idx);
  end

  // Datapath and output registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q         <= '0;
      frame_count_q <= '0;
      conv_done_q   <= 1'b0;
      s_ready_q     <= 1'b0;
      start_q       <= 1'b0;
      pixel_we_q    <= 1'b0;
      pixel_addr_q  <= '0;
      pixel_in_q    <= '0;
      frame_err_q   <= 1'b0;
    end else begin
      cnt_q         <= cnt_d;
      frame_count_q <= frame_count_d;
      conv_done_q   <= conv_done;
      s_ready_q     <= s_ready_d;
      start_q       <= start_d;
      pixel_we_q    <= pixel_we_d;
      pixel_addr_q  <= pixel_addr_d;
      pixel_in_q    <= pixel_in_d;
      frame_err_q   <= frame_err_d;
    end
  end

  assign s_ready     = s_ready_q;
  assign start       = start_q;
  assign pixel_we    = pixel_we_q;
  assign pixel_addr  = pixel_addr_q;
  assign pixel_in    = pixel_in_q;
  assign frame_err   = frame_err_q;
  assign frame_count = frame_count_q;
  assign busy        = (state_q != LOAD) | (cnt_q != '0);

endmodule
`default_nettype wire

// File: tb/tb_pixel_stream_loader.sv
`default_nettype none
// ============================================================================
//  Module      : tb_pixel_stream_loader
//  Description : Self-checking bench for pixel_stream_loader (4x4 frames).
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_pixel_stream_loader;

  localparam int W  = 4;
  localparam int H  = 4;
  localparam int N  = W * H;
  localparam int AW = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic [7:0]    s_data;
  logic          s_valid;
  logic          s_last;
  logic          s_ready;
  logic [7:0]    pixel_in;
  logic [AW-1:0] pixel_addr;
  logic          pixel_we;
  logic          start;
  logic          conv_done;
  logic          busy;
  logic          frame_err;
  logic [15:0]   frame_count;

  pixel_stream_loader #(
    .IMAGE_WIDTH (W),
    .IMAGE_HEIGHT(H),
    .ADDR_W      (AW)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .s_data     (s_data),
    .s_valid    (s_valid),
    .s_last     (s_last),
    .s_ready    (s_ready),
    .pixel_in   (pixel_in),
    .pixel_addr (pixel_addr),
    .pixel_we   (pixel_we),
    .start      (start),
    .conv_done  (conv_done),
    .busy       (busy),
    .frame_err  (frame_err),
    .frame_count(frame_count)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  task automatic chk(input string nm, input int act, input int exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  // phase: 0 loading, 1 gap, 2 start, 3 waiting for done
  int m_phase = 0, m_pos = 0, m_addr = 0, m_data = 0, m_fc = 0;
  bit m_ready = 0, m_we = 0, m_start = 0, m_err = 0, m_prev_done = 0;

  always @(posedge clk or posedge rst) begin : model
    bit acc;
    bit rise;
    if (rst) begin
      m_phase = 0; m_pos = 0; m_addr = 0; m_data = 0; m_fc = 0;
      m_ready = 0; m_we = 0; m_start = 0; m_err = 0; m_prev_done = 0;
    end else begin
      acc  = s_valid && m_ready;
      rise = conv_done && !m_prev_done;
      m_prev_done = conv_done;
      m_we    = acc;
      m_err   = acc && (s_last != (m_pos == N - 1));
      m_start = (m_phase == 1);
      if (acc) begin
        m_addr = m_pos;
        m_data = s_data;
      end
      case (m_phase)
        0: if (acc) begin
             if (m_pos == N - 1) begin m_pos = 0; m_phase = 1; end
             else if (s_last)     m_pos = 0;
             else                 m_pos = m_pos + 1;
           end
        1: m_phase = 2;
        2: m_phase = 3;
        default: if (rise) begin m_phase = 0; m_fc = (m_fc + 1) % 65536; end
      endcase
      m_ready = (m_phase == 0);
    end
  end

  // ---------------- compare + observation ----------------
  int n_we = 0, n_start = 0, n_err = 0;
  int wq[$];
  int dq[$];

  always @(negedge clk) begin
    chk("s_ready",     s_ready,     m_ready);
    chk("pixel_we",    pixel_we,    m_we);
    chk("pixel_addr",  pixel_addr,  m_addr);
    chk("pixel_in",    pixel_in,    m_data);
    chk("start",       start,       m_start);
    chk("frame_err",   frame_err,   m_err);
    chk("frame_count", frame_count, m_fc);
    chk("busy",        busy,        (m_phase != 0) || (m_pos != 0));
    tests++;
    if (start && pixel_we) begin
      fails++;
      $display("FAIL start_with_we: start=%0d pixel_we=%0d", start, pixel_we);
    end
    if (pixel_we) begin n_we++; wq.push_back(pixel_addr); dq.push_back(pixel_in); end
    if (start)     n_start++;
    if (frame_err) n_err++;
  end

  // ---------------- stimulus helpers ----------------
  task automatic cycles(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic clear_obs();
    n_we = 0; n_start = 0; n_err = 0;
    wq.delete(); dq.delete();
  endtask

  task automatic beat(input logic [7:0] d, input bit l, input bit keep);
    int n = 0;
    bit acc = 0;
    s_valid = 1'b1; s_data = d; s_last = l;
    while (!acc && n < 200) begin
      @(negedge clk); acc = s_ready;
      @(posedge clk); #1;
      n++;
    end
    if (!acc) chk("beat_timeout", 0, 1);
    if (!keep) begin s_valid = 1'b0; s_last = 1'b0; end
  endtask

  // last_at: 1-based beat carrying s_last, 0 for none
  task automatic frame(input int base, input int n, input int last_at, input bit gaps);
    for (int i = 0; i < n; i++) begin
      beat(8'(base + i), (i + 1 == last_at), !gaps && (i != n - 1));
      if (gaps) cycles(1);
    end
  endtask

  task automatic check_frame(input int base);
    chk("frame_writes", n_we, N);
    for (int i = 0; i < N; i++) begin
      if (i < wq.size()) begin
        chk("frame_addr", wq[i], i);
        chk("frame_data", dq[i], (base + i) % 256);
      end
    end
  endtask

  task automatic done_pulse();
    conv_done = 1'b1; cycles(1); conv_done = 1'b0;
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    rst = 1'b1; s_valid = 1'b0; s_data = 8'h00; s_last = 1'b0; conv_done = 1'b0;
    cycles(3);
    chk("rst_ready", s_ready, 0);
    chk("rst_busy", busy, 0);
    rst = 1'b0;
    @(negedge clk);
    chk("ready_before_edge", s_ready, 0);
    @(posedge clk); #1;
    chk("ready_after_rst", s_ready, 1);

    // Continuous frame 0x00..0x0F
    clear_obs();
    frame(8'h00, N, N, 1'b0);
    chk("t1_ready_after_last", s_ready, 0);
    cycles(5);
    check_frame(8'h00);
    chk("t1_starts", n_start, 1);
    chk("t1_errs", n_err, 0);

    // Engine slow to finish
    cycles(50);
    chk("wait_ready", s_ready, 0);
    chk("wait_fc", frame_count, 0);
    conv_done = 1'b1;
    cycles(1);
    chk("done_fc1", frame_count, 1);
    chk("done_ready", s_ready, 1);

    // Gapped frame with conv_done held high (stale level)
    clear_obs();
    frame(8'h40, N, N, 1'b1);
    cycles(20);
    check_frame(8'h40);
    chk("t2_starts", n_start, 1);
    chk("t2_stuck_ready", s_ready, 0);
    chk("t2_stuck_fc", frame_count, 1);
    conv_done = 1'b0;
    cycles(2);
    done_pulse();
    chk("t2_fc2", frame_count, 2);

    // Short frame (s_last on beat 5) then a full one
    clear_obs();
    frame(8'h80, 5, 5, 1'b0);
    cycles(2);
    chk("t3_err", n_err, 1);
    chk("t3_nostart", n_start, 0);
    chk("t3_busy", busy, 0);
    chk("t3_short_last_addr", pixel_addr, 4);
    wq.delete(); dq.delete(); n_we = 0;
    frame(8'h90, N, N, 1'b0);
    cycles(5);
    check_frame(8'h90);
    chk("t3_starts", n_start, 1);
    chk("t3_errs_total", n_err, 1);
    done_pulse();
    chk("t3_fc3", frame_count, 3);

    // Missing s_last
    clear_obs();
    frame(8'hA0, N, 0, 1'b0);
    chk("t4_err_now", frame_err, 1);
    cycles(5);
    chk("t4_errs", n_err, 1);
    chk("t4_starts", n_start, 1);
    done_pulse();
    chk("t4_fc4", frame_count, 4);

    // Reset mid-frame
    frame(8'hB0, 7, 0, 1'b0);
    chk("t5_busy_before", busy, 1);
    rst = 1'b1;
    #1;
    chk("t5_rst_ready", s_ready, 0);
    chk("t5_rst_we", pixel_we, 0);
    chk("t5_rst_addr", pixel_addr, 0);
    chk("t5_rst_in", pixel_in, 0);
    chk("t5_rst_start", start, 0);
    chk("t5_rst_err", frame_err, 0);
    chk("t5_rst_fc", frame_count, 0);
    chk("t5_rst_busy", busy, 0);
    cycles(2);
    rst = 1'b0;
    cycles(1);
    clear_obs();
    frame(8'hC0, N, N, 1'b0);
    cycles(5);
    check_frame(8'hC0);
    chk("t5_starts", n_start, 1);
    chk("t5_errs", n_err, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
`default_nettype wire
